// File: rtl/udp_fragment_slot_manager.sv
// IPv4 fragment reassembly slot tracker: per-slot lifecycle plus round-robin offer of completed datagrams.
// Age-based reclaim of stalled FILLING slots is built only when UDP_FRAGMENT_SLOT_TIMEOUT_EN is defined.
module udp_fragment_slot_manager #(
    parameter int unsigned FRAGMENT_SLOTS = 4,
    parameter logic [15:0] AGE_LIMIT      = 16'd50000
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic [FRAGMENT_SLOTS-1:0]         i_push_data_valid,
    input  logic [FRAGMENT_SLOTS-1:0]         i_push_data_last,
    input  logic [15:0]                       i_packet_id,
    output logic [FRAGMENT_SLOTS-1:0]         o_fragment_slot_empty,
    output logic [FRAGMENT_SLOTS*16-1:0]      o_fragment_slot_packet_id,
    output logic                              o_complete_valid,
    input  logic                              i_complete_ready,
    output logic [$clog2(FRAGMENT_SLOTS)-1:0] o_complete_slot,
    output logic [15:0]                       o_complete_packet_id,
    output logic [15:0]                       o_complete_byte_count,
    input  logic                              i_release,
    input  logic [$clog2(FRAGMENT_SLOTS)-1:0] i_release_slot,
    output logic                              o_timeout_drop,
    output logic [$clog2(FRAGMENT_SLOTS)-1:0] o_timeout_slot,
    output logic                              o_protocol_error
);
    localparam int unsigned SW = $clog2(FRAGMENT_SLOTS);

    typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_COMPLETE, S_READING} slot_state_t;

    slot_state_t               r_state      [FRAGMENT_SLOTS];
    slot_state_t               w_state_next [FRAGMENT_SLOTS];
    logic [15:0]               r_packet_id  [FRAGMENT_SLOTS];
    logic [15:0]               r_byte_count [FRAGMENT_SLOTS];
    logic [SW-1:0]             r_rr_ptr;
    logic                      w_pick_found;
    logic [SW-1:0]             w_pick_slot;
    logic                      w_handshake;
    logic                      w_expire_found;
    logic [SW-1:0]             w_expire_slot;
    logic [FRAGMENT_SLOTS-1:0] w_bad_push;

    assign w_handshake = o_complete_valid && i_complete_ready;

    for (genvar g = 0; g < FRAGMENT_SLOTS; g++) begin : g_pid_out
        assign o_fragment_slot_packet_id[g*16 +: 16] = r_packet_id[g];
    end

`ifdef UDP_FRAGMENT_SLOT_TIMEOUT_EN
    logic [15:0]               r_age [FRAGMENT_SLOTS];
    logic [FRAGMENT_SLOTS-1:0] w_age_due;

    // Due when this idle cycle brings the age to the limit, or it is already held there awaiting report.
    always_comb begin
        w_expire_found = 1'b0;
        w_expire_slot  = '0;
        w_age_due      = '0;
        for (int i = int'(FRAGMENT_SLOTS) - 1; i >= 0; i--) begin
            w_age_due[i] = (r_state[i] == S_FILLING) && !i_push_data_valid[i] && !i_push_data_last[i]
                           && ((17'(r_age[i]) + 17'd1) >= 17'(AGE_LIMIT));
            if (w_age_due[i]) begin
                w_expire_found = 1'b1;
                w_expire_slot  = SW'(i);
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < int'(FRAGMENT_SLOTS); i++) begin
                r_age[i] <= '0;
            end
            o_timeout_drop <= 1'b0;
            o_timeout_slot <= '0;
        end else begin
            for (int i = 0; i < int'(FRAGMENT_SLOTS); i++) begin
                if (r_state[i] == S_EMPTY || i_push_data_valid[i]) begin
                    r_age[i] <= '0;
                end else if (r_state[i] == S_FILLING) begin
                    r_age[i] <= w_age_due[i] ? AGE_LIMIT : r_age[i] + 16'd1;
                end
            end
            o_timeout_drop <= w_expire_found;
            if (w_expire_found) begin
                o_timeout_slot <= w_expire_slot;
            end
        end
    end
`else
    assign w_expire_found = 1'b0;
    assign w_expire_slot  = '0;
    assign o_timeout_drop = 1'b0;
    assign o_timeout_slot = '0;
`endif

    // Round-robin pick: the COMPLETE slot closest at or after the pointer wins.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_slot  = '0;
        for (int k = int'(FRAGMENT_SLOTS) - 1; k >= 0; k--) begin
            if (r_state[SW'((int'(r_rr_ptr) + k) % int'(FRAGMENT_SLOTS))] == S_COMPLETE) begin
                w_pick_found = 1'b1;
                w_pick_slot  = SW'((int'(r_rr_ptr) + k) % int'(FRAGMENT_SLOTS));
            end
        end
    end

    always_comb begin
        w_bad_push = '0;
        for (int i = 0; i < int'(FRAGMENT_SLOTS); i++) begin
            w_state_next[i] = r_state[i];
            case (r_state[i])
                S_EMPTY: begin
                    if (i_push_data_valid[i]) w_state_next[i] = S_FILLING;
                end
                S_FILLING: begin
                    if (i_push_data_last[i]) begin
                        w_state_next[i] = S_COMPLETE;
                    end else if (w_expire_found && (w_expire_slot == SW'(i))) begin
                        w_state_next[i] = S_EMPTY;
                    end
                end
                S_COMPLETE: begin
                    w_bad_push[i] = i_push_data_valid[i] || i_push_data_last[i];
                    if (w_handshake && (o_complete_slot == SW'(i))) w_state_next[i] = S_READING;
                end
                S_READING: begin
                    w_bad_push[i] = i_push_data_valid[i] || i_push_data_last[i];
                    if (i_release && (i_release_slot == SW'(i))) w_state_next[i] = S_EMPTY;
                end
                default: w_state_next[i] = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < int'(FRAGMENT_SLOTS); i++) begin
                r_state[i]      <= S_EMPTY;
                r_packet_id[i]  <= '0;
                r_byte_count[i] <= '0;
            end
            o_fragment_slot_empty <= '1;
            o_complete_valid      <= 1'b0;
            o_complete_slot       <= '0;
            o_complete_packet_id  <= '0;
            o_complete_byte_count <= '0;
            o_protocol_error      <= 1'b0;
            r_rr_ptr              <= '0;
        end else begin
            for (int i = 0; i < int'(FRAGMENT_SLOTS); i++) begin
                r_state[i]               <= w_state_next[i];
                o_fragment_slot_empty[i] <= (w_state_next[i] == S_EMPTY);
                if (r_state[i] == S_EMPTY && i_push_data_valid[i]) begin
                    r_packet_id[i]  <= i_packet_id;
                    r_byte_count[i] <= 16'd1;
                end else if (r_state[i] == S_FILLING && i_push_data_valid[i]
                             && r_byte_count[i] != 16'hFFFF) begin
                    r_byte_count[i] <= r_byte_count[i] + 16'd1;
                end
            end
            if (|w_bad_push) begin
                o_protocol_error <= 1'b1;
            end
            // Offer fields stay frozen while valid; one dead cycle follows each handshake.
            if (o_complete_valid) begin
                if (i_complete_ready) begin
                    o_complete_valid <= 1'b0;
                    r_rr_ptr <= (o_complete_slot == SW'(FRAGMENT_SLOTS - 1)) ? '0
                                : o_complete_slot + SW'(1);
                end
            end else if (w_pick_found) begin
                o_complete_valid      <= 1'b1;
                o_complete_slot       <= w_pick_slot;
                o_complete_packet_id  <= r_packet_id[w_pick_slot];
                o_complete_byte_count <= r_byte_count[w_pick_slot];
            end
        end
    end
endmodule

// File: tb/tb_udp_fragment_slot_manager.sv
// Bench for udp_fragment_slot_manager: directed scenarios plus randomized traffic against a slot-level model.
module tb_udp_fragment_slot_manager;
    localparam int N   = 4;
    localparam int AGE = 8;
`ifdef UDP_FRAGMENT_SLOT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int M_EMPTY = 0, M_FILLING = 1, M_COMPLETE = 2, M_READING = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  push_v = '0;
    logic [N-1:0]  push_l = '0;
    logic [15:0]   pid = '0;
    logic          ready = 1'b0;
    logic          rel = 1'b0;
    logic [1:0]    rel_slot = '0;
    logic [N-1:0]  o_empty;
    logic [N*16-1:0] o_pids;
    logic          o_cvalid;
    logic [1:0]    o_cslot;
    logic [15:0]   o_cpid;
    logic [15:0]   o_cbc;
    logic          o_tdrop;
    logic [1:0]    o_tslot;
    logic          o_perr;

    int n_checks = 0;
    int n_errors = 0;
    int n_drops  = 0;
    int cyc      = 0;
    int grant_q[$];
    int grant_t[$];

    // Slot-level reference model
    int          m_st   [N];
    logic [15:0] m_pid  [N];
    int          m_bc   [N];
    int          m_idle [N];
    bit          m_off_valid;
    int          m_off_slot, m_off_pid, m_off_bc, m_last_grant;
    bit          m_err, m_tdrop;
    int          m_tslot;

    udp_fragment_slot_manager #(.FRAGMENT_SLOTS(N), .AGE_LIMIT(16'(AGE))) dut (
        .i_clock(clk), .i_reset(rst),
        .i_push_data_valid(push_v), .i_push_data_last(push_l), .i_packet_id(pid),
        .o_fragment_slot_empty(o_empty), .o_fragment_slot_packet_id(o_pids),
        .o_complete_valid(o_cvalid), .i_complete_ready(ready),
        .o_complete_slot(o_cslot), .o_complete_packet_id(o_cpid), .o_complete_byte_count(o_cbc),
        .i_release(rel), .i_release_slot(rel_slot),
        .o_timeout_drop(o_tdrop), .o_timeout_slot(o_tslot), .o_protocol_error(o_perr)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = M_EMPTY; m_pid[i] = '0; m_bc[i] = 0; m_idle[i] = 0;
        end
        m_off_valid = 1'b0; m_off_slot = 0; m_off_pid = 0; m_off_bc = 0;
        m_last_grant = N - 1;
        m_err = 1'b0; m_tdrop = 1'b0; m_tslot = 0;
    endfunction

    function automatic void model_step();
        int  nst[N];
        int  expired;
        bit  hs;
        hs = m_off_valid && ready;
        expired = -1;
        for (int i = 0; i < N; i++) begin
            if ((m_st[i] == M_COMPLETE || m_st[i] == M_READING) && (push_v[i] || push_l[i])) m_err = 1'b1;
            if (TO_EN && m_st[i] == M_FILLING && !push_v[i] && !push_l[i]
                && m_idle[i] + 1 >= AGE && expired < 0) expired = i;
        end
        for (int i = 0; i < N; i++) begin
            nst[i] = m_st[i];
            case (m_st[i])
                M_EMPTY: if (push_v[i]) begin
                    nst[i] = M_FILLING; m_pid[i] = pid; m_bc[i] = 1; m_idle[i] = 0;
                end
                M_FILLING: begin
                    if (push_v[i]) begin
                        if (m_bc[i] < 65535) m_bc[i]++;
                        m_idle[i] = 0;
                    end else m_idle[i]++;
                    if (push_l[i]) nst[i] = M_COMPLETE;
                    else if (expired == i) nst[i] = M_EMPTY;
                end
                M_COMPLETE: if (hs && m_off_slot == i) nst[i] = M_READING;
                default: if (rel && int'(rel_slot) == i) nst[i] = M_EMPTY;
            endcase
        end
        if (hs) begin
            m_off_valid  = 1'b0;
            m_last_grant = m_off_slot;
        end else if (!m_off_valid) begin
            for (int k = 1; k <= N; k++) begin
                int s;
                s = (m_last_grant + k) % N;
                if (!m_off_valid && m_st[s] == M_COMPLETE) begin
                    m_off_valid = 1'b1; m_off_slot = s; m_off_pid = int'(m_pid[s]); m_off_bc = m_bc[s];
                end
            end
        end
        for (int i = 0; i < N; i++) m_st[i] = nst[i];
        m_tdrop = (expired >= 0);
        if (expired >= 0) m_tslot = expired;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            if (o_cvalid && ready) begin
                grant_q.push_back(int'(o_cslot));
                grant_t.push_back(cyc);
            end
            model_step();
            cyc++;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            logic [N-1:0]    e_empty;
            logic [N*16-1:0] e_pids;
            for (int i = 0; i < N; i++) begin
                e_empty[i] = (m_st[i] == M_EMPTY);
                e_pids[i*16 +: 16] = m_pid[i];
            end
            check("empty", o_empty, e_empty);
            check("slot_pids", o_pids, e_pids);
            check("cvalid", o_cvalid, m_off_valid);
            if (m_off_valid) begin
                check("cslot", o_cslot, m_off_slot);
                check("cpid", o_cpid, m_off_pid);
                check("cbc", o_cbc, m_off_bc);
            end
            check("tdrop", o_tdrop, m_tdrop);
            if (m_tdrop) check("tslot", o_tslot, m_tslot);
            check("perr", o_perr, m_err);
            if (o_tdrop) n_drops++;
        end
    end

    task automatic idle_in();
        push_v = '0; push_l = '0; ready = 1'b0; rel = 1'b0; rel_slot = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); idle_in(); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        while (!o_cvalid && n < max_cyc) begin @(negedge clk); n++; end
        check("offer_wait", o_cvalid, 1'b1);
    endtask

    task automatic rand_cycle(input int push_pct, input int last_pct, input bit allow_err);
        int rs;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            push_v[i] = 1'b0; push_l[i] = 1'b0;
            case (m_st[i])
                M_EMPTY:   begin push_v[i] = ($urandom_range(0, 99) < push_pct); push_l[i] = ($urandom_range(0, 99) < 3); end
                M_FILLING: begin push_v[i] = ($urandom_range(0, 99) < push_pct); push_l[i] = ($urandom_range(0, 99) < last_pct); end
                default:   push_v[i] = allow_err && ($urandom_range(0, 199) == 0);
            endcase
        end
        pid   = 16'($urandom);
        ready = ($urandom_range(0, 99) < 60);
        rs    = $urandom_range(0, N - 1);
        rel_slot = 2'(rs);
        rel   = (m_st[rs] == M_READING) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] drops_before;
        int n;
        // Reset values
        @(negedge clk);
        check("rst_empty", o_empty, 4'b1111);
        check("rst_cvalid", o_cvalid, 1'b0);
        check("rst_pids", o_pids, 64'h0);
        check("rst_perr", o_perr, 1'b0);
        check("rst_tdrop", o_tdrop, 1'b0);
        @(negedge clk); rst = 1'b0;

        // 10 bytes into slot 0, then last
        for (int k = 0; k < 10; k++) begin @(negedge clk); push_v = 4'b0001; pid = 16'h1234; end
        @(negedge clk); push_v = '0; push_l = 4'b0001;
        @(negedge clk); push_l = '0;
        wait_valid(6);
        check("t1_slot", o_cslot, 2'd0);
        check("t1_pid", o_cpid, 16'h1234);
        check("t1_bc", o_cbc, 16'd10);
        check("t1_empty0", o_empty[0], 1'b0);
        repeat (3) @(negedge clk);
        check("t1_hold", {o_cvalid, o_cslot, o_cbc}, {1'b1, 2'd0, 16'd10});

        // Slots 1..3 complete together, ready held high
        do_reset();
        grant_q.delete(); grant_t.delete();
        @(negedge clk); push_v = 4'b1110; pid = 16'hA000;
        @(negedge clk); push_v = '0; push_l = 4'b1110; ready = 1'b1;
        @(negedge clk); push_l = '0;
        repeat (10) @(negedge clk);
        ready = 1'b0;
        check("t2_ngrants", grant_q.size(), 3);
        if (grant_q.size() == 3) begin
            check("t2_order", {grant_q[0][1:0], grant_q[1][1:0], grant_q[2][1:0]}, {2'd1, 2'd2, 2'd3});
            check("t2_gap", {grant_t[1] - grant_t[0], grant_t[2] - grant_t[1]}, {32'd2, 32'd2});
        end
        @(negedge clk); rel = 1'b1; rel_slot = 2'd2;
        @(negedge clk); rel = 1'b0;
        check("t2_release", o_empty, 4'b0101);

        // Age timeout on slot 1
        do_reset();
        @(negedge clk); push_v = 4'b0010; pid = 16'h0BEE;
        @(negedge clk); push_v = '0; n = 1;
        while (!o_tdrop && n < 40) begin @(negedge clk); n++; end
        check("t3_latency", n, TO_EN ? 9 : 40);
        check("t3_slot", o_tslot, TO_EN ? 2'd1 : 2'd0);
        @(negedge clk);
        check("t3_pulse", o_tdrop, 1'b0);
        check("t3_empty1", o_empty[1], TO_EN);

        // Two slots expire together: lowest first, then the other
        do_reset();
        @(negedge clk); push_v = 4'b0101;
        @(negedge clk); push_v = '0;
        repeat (8) @(negedge clk);
        check("t3m_first", {o_tdrop, o_tslot}, TO_EN ? 3'b100 : 3'b000);
        @(negedge clk);
        check("t3m_second", {o_tdrop, o_tslot}, TO_EN ? 3'b110 : 3'b000);
        @(negedge clk);
        check("t3m_empty", o_empty, TO_EN ? 4'b1111 : 4'b1010);

        // Last on the cycle the age reaches the limit
        do_reset();
        drops_before = N'(n_drops);
        @(negedge clk); push_v = 4'b0010; pid = 16'h5555;
        @(negedge clk); push_v = '0;
        repeat (6) @(negedge clk);
        @(negedge clk); push_l = 4'b0010;
        @(negedge clk); push_l = '0;
        repeat (3) @(negedge clk);
        check("t4_nodrop", N'(n_drops), drops_before);
        check("t4_offer", {o_cvalid, o_cslot, o_cbc}, {1'b1, 2'd1, 16'd1});

        // Push into a READING slot, release an EMPTY slot
        do_reset();
        @(negedge clk); push_v = 4'b0001; pid = 16'h7777;
        @(negedge clk); push_v = '0; push_l = 4'b0001;
        @(negedge clk); push_l = '0;
        wait_valid(6);
        ready = 1'b1;
        @(negedge clk); ready = 1'b0; push_v = 4'b0001;
        @(negedge clk); push_v = '0; rel = 1'b1; rel_slot = 2'd2;
        @(negedge clk); rel = 1'b0;
        check("t5_perr", o_perr, 1'b1);
        check("t5_empty", o_empty, 4'b1110);
        repeat (3) @(negedge clk);
        check("t5_sticky", {o_perr, o_empty}, {1'b1, 4'b1110});
        rel = 1'b1; rel_slot = 2'd0;
        @(negedge clk); rel = 1'b0;
        check("t5_free", {o_perr, o_empty}, {1'b1, 4'b1111});

        // Mid-cycle reset with slot 0 offered and slots 1..3 filling
        push_v = 4'b0001; pid = 16'h4242;
        @(negedge clk); push_v = '0; push_l = 4'b0001;
        @(negedge clk); push_l = '0;
        wait_valid(6);
        push_v = 4'b1110; pid = 16'h9999;
        @(negedge clk); push_v = '0;
        #2 rst = 1'b1;
        #1;
        check("t6_empty", o_empty, 4'b1111);
        check("t6_offer", {o_cvalid, o_cslot, o_cpid, o_cbc}, 35'h0);
        check("t6_misc", {o_pids, o_tdrop, o_perr}, 66'h0);
        @(negedge clk); @(negedge clk); rst = 1'b0;

        // Randomized traffic phases: busy, sparse (timeouts), error-tolerant
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            for (int c = 0; c < 1000; c++) begin
                case (ph)
                    0:       rand_cycle(60, 8, 1'b0);
                    1:       rand_cycle(6, 3, 1'b0);
                    default: rand_cycle(30, 6, 1'b1);
                endcase
            end
        end
        @(negedge clk); idle_in();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
